// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote tally block and its max scanner.
package vote_pkg;

  // Widest candidate vector the priority encoder handles.
  localparam int unsigned MAX_CAND     = 32;
  localparam int unsigned DEF_NUM_CAND = 4;
  localparam int unsigned DEF_CNT_W    = 8;

  typedef enum logic {
    ARMED,
    WAIT_RELEASE
  } ballot_state_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } scan_state_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic int unsigned lowest_set(input logic [MAX_CAND-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = int'(MAX_CAND) - 1; i >= 0; i--) begin
      if (v[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vote_max_scan.sv
// Sequential max-finder: one candidate per cycle, lowest index wins ties.
module vote_max_scan
  import vote_pkg::*;
#(
  parameter int unsigned NUM_CAND = DEF_NUM_CAND,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  localparam int unsigned IDX_W   = $clog2(NUM_CAND)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [NUM_CAND*CNT_W-1:0] counts,
  output logic [IDX_W-1:0]          winner_idx,
  output logic                      tie,
  output logic                      done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

  scan_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [IDX_W-1:0] win_q, win_d;
  logic             tie_q, tie_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cur_c;

  // Select the count currently being visited.
  always_comb begin
    cur_c = '0;
    for (int i = 0; i < int'(NUM_CAND); i++) begin
      if (idx_q == IDX_W'(i)) cur_c = counts[i*CNT_W +: CNT_W];
    end
  end

  // Scan FSM next state and running max/index/tie.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    max_d   = max_q;
    win_d   = win_q;
    tie_d   = tie_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end else begin
          if (idx_q == '0) begin
            max_d = cur_c;
            win_d = '0;
            tie_d = 1'b0;
          end else if (cur_c > max_q) begin
            max_d = cur_c;
            win_d = idx_q;
            tie_d = 1'b0;
          end else if (cur_c == max_q) begin
            tie_d = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  // Scan state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      max_q   <= '0;
      win_q   <= '0;
      tie_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      max_q   <= max_d;
      win_q   <= win_d;
      tie_q   <= tie_d;
      done_q  <= done_d;
    end
  end

  assign winner_idx = win_q;
  assign tie        = tie_q;
  assign done       = done_q;

endmodule

// File: rtl/vote_tally.sv
// Per-candidate saturating vote counters with one-count-per-press ballot FSM.
module vote_tally
  import vote_pkg::*;
#(
  parameter int unsigned NUM_CAND = DEF_NUM_CAND,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  localparam int unsigned IDX_W   = $clog2(NUM_CAND),
  localparam int unsigned TOT_W   = CNT_W + IDX_W
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      mode,
  input  logic [NUM_CAND-1:0]       vote_valid,
  output logic [NUM_CAND*CNT_W-1:0] cand_votes,
  output logic [TOT_W-1:0]          total_votes,
  output logic [NUM_CAND-1:0]       cand_sat,
  output logic                      vote_ack,
  output logic [IDX_W-1:0]          winner_idx,
  output logic                      winner_valid,
  output logic                      tie
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ballot_state_t         bstate_q, bstate_d;
  logic                  ack_q, ack_d;
  logic                  accept_c;
  logic [IDX_W-1:0]      sel_c;
  logic                  inc_c;
  logic [CNT_W-1:0]      cnt_q [NUM_CAND];
  logic [CNT_W-1:0]      cnt_d [NUM_CAND];
  logic [TOT_W-1:0]      total_q, total_d;
  logic [NUM_CAND-1:0]   sat_q, sat_d;
  logic                  mode_q, mode_d;
  logic                  mode_prev_q, mode_prev_d;
  logic                  scan_start_c;
  logic                  scan_abort_c;
  logic [NUM_CAND*CNT_W-1:0] cnt_flat;

  // Multi-button presses count only for the lowest pressed candidate.
  assign sel_c = IDX_W'(lowest_set(MAX_CAND'(vote_valid)));

  // Ballot FSM: accept once per press, then wait for full release.
  always_comb begin
    bstate_d = bstate_q;
    ack_d    = 1'b0;
    accept_c = 1'b0;
    case (bstate_q)
      ARMED: begin
        if (|vote_valid) begin
          bstate_d = WAIT_RELEASE;
          if (!mode) begin
            accept_c = 1'b1;
            ack_d    = 1'b1;
          end
        end
      end
      WAIT_RELEASE: begin
        if (vote_valid == '0) bstate_d = ARMED;
      end
      default: bstate_d = ARMED;
    endcase
  end

  // Saturating counter update, running total and sticky saturation flags.
  always_comb begin
    cnt_d = cnt_q;
    inc_c = 1'b0;
    for (int i = 0; i < int'(NUM_CAND); i++) begin
      if (accept_c && (sel_c == IDX_W'(i)) && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
        inc_c    = 1'b1;
      end
    end
    total_d = total_q + TOT_W'(inc_c);
    for (int i = 0; i < int'(NUM_CAND); i++) begin
      sat_d[i] = sat_q[i] | (cnt_d[i] == CNT_MAX);
    end
  end

  // Mode history for rising-edge detection of result mode.
  always_comb begin
    mode_d      = mode;
    mode_prev_d = mode_q;
  end

  // Ballot, counter and mode registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bstate_q    <= ARMED;
      ack_q       <= 1'b0;
      total_q     <= '0;
      sat_q       <= '0;
      mode_q      <= 1'b0;
      mode_prev_q <= 1'b0;
      for (int i = 0; i < int'(NUM_CAND); i++) cnt_q[i] <= '0;
    end else begin
      bstate_q    <= bstate_d;
      ack_q       <= ack_d;
      total_q     <= total_d;
      sat_q       <= sat_d;
      mode_q      <= mode_d;
      mode_prev_q <= mode_prev_d;
      for (int i = 0; i < int'(NUM_CAND); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < int'(NUM_CAND); g++) begin : g_flat
    assign cnt_flat[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  // Scan starts on the registered rise of mode; any low mode level stops it.
  assign scan_start_c = mode_q & ~mode_prev_q;
  assign scan_abort_c = ~mode;

  vote_max_scan #(
    .NUM_CAND (NUM_CAND),
    .CNT_W    (CNT_W)
  ) u_scan (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (scan_start_c),
    .abort      (scan_abort_c),
    .counts     (cnt_flat),
    .winner_idx (winner_idx),
    .tie        (tie),
    .done       (winner_valid)
  );

  assign cand_votes  = cnt_flat;
  assign total_votes = total_q;
  assign cand_sat    = sat_q;
  assign vote_ack    = ack_q;

endmodule

// File: tb/tb_vote_tally.sv
// Directed bench for vote_tally: default instance plus a 4-bit counter instance.
module tb_vote_tally;

  localparam int unsigned N   = 4;
  localparam int unsigned CW  = 8;
  localparam int unsigned IW  = 2;
  localparam int unsigned TW  = CW + IW;
  localparam int unsigned CW2 = 4;
  localparam int unsigned TW2 = CW2 + IW;

  logic            clock;
  logic            reset_n;
  logic            mode, mode2;
  logic [N-1:0]    vote_valid, vote_valid2;
  logic [N*CW-1:0] cand_votes;
  logic [TW-1:0]   total_votes;
  logic [N-1:0]    cand_sat;
  logic            vote_ack;
  logic [IW-1:0]   winner_idx;
  logic            winner_valid;
  logic            tie;
  logic [N*CW2-1:0] cand_votes2;
  logic [TW2-1:0]  total_votes2;
  logic [N-1:0]    cand_sat2;
  logic            vote_ack2;
  logic [IW-1:0]   winner_idx2;
  logic            winner_valid2;
  logic            tie2;

  int errors;
  int checks;

  vote_tally #(.NUM_CAND(N), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .mode(mode), .vote_valid(vote_valid),
    .cand_votes(cand_votes), .total_votes(total_votes), .cand_sat(cand_sat),
    .vote_ack(vote_ack), .winner_idx(winner_idx), .winner_valid(winner_valid),
    .tie(tie)
  );

  vote_tally #(.NUM_CAND(N), .CNT_W(CW2)) dut4 (
    .clock(clock), .reset_n(reset_n), .mode(mode2), .vote_valid(vote_valid2),
    .cand_votes(cand_votes2), .total_votes(total_votes2), .cand_sat(cand_sat2),
    .vote_ack(vote_ack2), .winner_idx(winner_idx2), .winner_valid(winner_valid2),
    .tie(tie2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic int cnt_of(input int i);
    return int'(cand_votes[i*CW +: CW]);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset_n     = 1'b0;
    mode        = 1'b0;
    mode2       = 1'b0;
    vote_valid  = '0;
    vote_valid2 = '0;
    step();
    @(posedge clock);
    #4;
    reset_n = 1'b1;
    step();
  endtask

  task automatic cast_vote(input int idx);
    vote_valid      = '0;
    vote_valid[idx] = 1'b1;
    step();
    vote_valid = '0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (cand_votes !== '0) begin errors++; $display("FAIL reset_cand_votes: got %h expected 0", cand_votes); end
    checks++;
    if (total_votes !== '0) begin errors++; $display("FAIL reset_total: got %0d expected 0", total_votes); end
    checks++;
    if ({cand_sat, vote_ack, winner_valid, tie, winner_idx} !== '0) begin
      errors++;
      $display("FAIL reset_flags: sat=%b ack=%b wv=%b tie=%b idx=%0d expected all 0",
               cand_sat, vote_ack, winner_valid, tie, winner_idx);
    end
  endtask

  task automatic test_single_press();
    int acks;
    acks = 0;
    vote_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      step();
      if (vote_ack === 1'b1) acks++;
      if (k == 0) begin
        checks++;
        if (vote_ack !== 1'b1) begin errors++; $display("FAIL single_ack_latency: got %b expected 1", vote_ack); end
      end
    end
    vote_valid = '0;
    step();
    checks++;
    if (acks != 1) begin errors++; $display("FAIL single_ack_count: got %0d expected 1", acks); end
    checks++;
    if (cand_votes !== {8'd0, 8'd1, 8'd0, 8'd0}) begin
      errors++; $display("FAIL single_counts: got %h expected 00010000", cand_votes);
    end
    checks++;
    if (total_votes !== 10'd1) begin errors++; $display("FAIL single_total: got %0d expected 1", total_votes); end
  endtask

  task automatic test_multi_press();
    vote_valid = 4'b1010;
    step();
    checks++;
    if (vote_ack !== 1'b1) begin errors++; $display("FAIL multi_ack: got %b expected 1", vote_ack); end
    vote_valid = '0;
    step();
    checks++;
    if (cnt_of(1) != 1 || cnt_of(3) != 0) begin
      errors++; $display("FAIL multi_lowest: got c1=%0d c3=%0d expected c1=1 c3=0", cnt_of(1), cnt_of(3));
    end
    cast_vote(3);
    checks++;
    if (cand_votes !== {8'd1, 8'd1, 8'd1, 8'd0} || total_votes !== 10'd3) begin
      errors++; $display("FAIL multi_after_c3: got %h total %0d expected 01010100 total 3", cand_votes, total_votes);
    end
  endtask

  task automatic test_back_to_back();
    int acks;
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      vote_valid = 4'b0001;
      step();
      if (vote_ack === 1'b1) acks++;
      vote_valid = '0;
      step();
    end
    checks++;
    if (acks != 3 || cnt_of(0) != 3 || total_votes !== 10'd6) begin
      errors++;
      $display("FAIL back_to_back: got acks=%0d c0=%0d total=%0d expected 3 3 6", acks, cnt_of(0), total_votes);
    end
  endtask

  task automatic test_hold_across_mode();
    int acks;
    acks = 0;
    mode       = 1'b1;
    vote_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      step();
      if (vote_ack === 1'b1) acks++;
    end
    mode = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (vote_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0 || cnt_of(0) != 3 || total_votes !== 10'd6) begin
      errors++; $display("FAIL hold_mode_blocked: got acks=%0d c0=%0d total=%0d expected 0 3 6", acks, cnt_of(0), total_votes);
    end
    vote_valid = '0;
    step();
    cast_vote(0);
    checks++;
    if (cnt_of(0) != 4 || total_votes !== 10'd7) begin
      errors++; $display("FAIL hold_mode_repress: got c0=%0d total=%0d expected 4 7", cnt_of(0), total_votes);
    end
  endtask

  task automatic test_scan();
    int          early;
    logic [IW-1:0] exp_idx [3];
    logic          exp_tie [3];
    exp_idx[0] = 2'd0; exp_tie[0] = 1'b1;
    exp_idx[1] = 2'd1; exp_tie[1] = 1'b1;
    exp_idx[2] = 2'd1; exp_tie[2] = 1'b0;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      if (p == 1) begin
        for (int k = 0; k < 3; k++) cast_vote(0);
        for (int k = 0; k < 7; k++) cast_vote(1);
        for (int k = 0; k < 7; k++) cast_vote(2);
        cast_vote(3);
      end
      if (p == 2) cast_vote(1);
      mode  = 1'b1;
      early = 0;
      for (int k = 0; k <= int'(N); k++) begin
        step();
        if (winner_valid !== 1'b0) early++;
      end
      step();
      checks++;
      if (early != 0 || winner_valid !== 1'b1) begin
        errors++; $display("FAIL scan_latency_%0d: early=%0d wv=%b expected 0 then 1", p, early, winner_valid);
      end
      checks++;
      if (winner_idx !== exp_idx[p] || tie !== exp_tie[p]) begin
        errors++;
        $display("FAIL scan_result_%0d: got idx=%0d tie=%b expected idx=%0d tie=%b",
                 p, winner_idx, tie, exp_idx[p], exp_tie[p]);
      end
      step();
      checks++;
      if (winner_valid !== 1'b1) begin errors++; $display("FAIL scan_hold_%0d: got wv=%b expected 1", p, winner_valid); end
      mode = 1'b0;
      step();
      checks++;
      if (winner_valid !== 1'b0) begin errors++; $display("FAIL scan_exit_%0d: got wv=%b expected 0", p, winner_valid); end
    end
  endtask

  task automatic test_scan_abort();
    int seen;
    seen = 0;
    mode = 1'b1;
    step();
    step();
    step();
    mode = 1'b0;
    for (int k = 0; k < int'(N) + 3; k++) begin
      step();
      if (winner_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL scan_abort: got %0d cycles with wv=1 expected 0", seen); end
  endtask

  task automatic test_async_reset();
    mode = 1'b1;
    step();
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (cand_votes !== '0 || total_votes !== '0 || cand_sat !== '0) begin
      errors++; $display("FAIL async_reset_counts: got %h total %0d sat %b expected 0", cand_votes, total_votes, cand_sat);
    end
    checks++;
    if ({vote_ack, winner_valid, tie, winner_idx} !== '0) begin
      errors++; $display("FAIL async_reset_flags: got ack=%b wv=%b tie=%b idx=%0d expected 0", vote_ack, winner_valid, tie, winner_idx);
    end
    #2;
    mode    = 1'b0;
    reset_n = 1'b1;
    step();
    cast_vote(3);
    checks++;
    if (cand_votes !== {8'd1, 8'd0, 8'd0, 8'd0} || total_votes !== 10'd1) begin
      errors++; $display("FAIL async_reset_next: got %h total %0d expected 01000000 total 1", cand_votes, total_votes);
    end
  endtask

  task automatic test_saturation();
    int acks;
    acks = 0;
    do_reset();
    for (int p = 0; p < 17; p++) begin
      vote_valid2 = 4'b0001;
      step();
      if (vote_ack2 === 1'b1) acks++;
      if (p == 13) begin
        checks++;
        if (cand_sat2[0] !== 1'b0 || cand_votes2[3:0] !== 4'd14) begin
          errors++; $display("FAIL sat_before: got sat=%b c0=%0d expected 0 14", cand_sat2[0], cand_votes2[3:0]);
        end
      end
      if (p == 14) begin
        checks++;
        if (cand_sat2[0] !== 1'b1 || cand_votes2[3:0] !== 4'd15) begin
          errors++; $display("FAIL sat_reached: got sat=%b c0=%0d expected 1 15", cand_sat2[0], cand_votes2[3:0]);
        end
      end
      vote_valid2 = '0;
      step();
    end
    checks++;
    if (acks != 17) begin errors++; $display("FAIL sat_acks: got %0d expected 17", acks); end
    checks++;
    if (cand_votes2 !== 16'h000f || total_votes2 !== 6'd15 || cand_sat2 !== 4'b0001) begin
      errors++; $display("FAIL sat_final: got %h total %0d sat %b expected 000f 15 0001", cand_votes2, total_votes2, cand_sat2);
    end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    reset_n     = 1'b0;
    mode        = 1'b0;
    mode2       = 1'b0;
    vote_valid  = '0;
    vote_valid2 = '0;
    test_reset();
    test_single_press();
    test_multi_press();
    test_back_to_back();
    test_hold_across_mode();
    test_scan();
    test_scan_abort();
    test_async_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
